// File: rtl/result_packer_if.sv
// result_packer_if: result stream in, packed output word stream out.
// Latency: none (wires only).
// Backpressure: out_ready throttles out_data/out_valid; the result side has no backpressure.
interface result_packer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_ROWS   = 64,
    parameter int BANDWIDTH  = 16
);
    localparam int CNT_W = $clog2(MAX_ROWS) + 1;

    logic                             start;
    logic [CNT_W-1:0]                 num_rows;
    logic signed [2*DATA_WIDTH-1:0]   result_in;
    logic                             result_valid;
    logic [DATA_WIDTH*BANDWIDTH-1:0]  out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic                             out_last;

    // Producer/consumer side (drives results, accepts packed words)
    modport master (
        output start, num_rows, result_in, result_valid, out_ready,
        input  out_data, out_valid, out_last
    );

    // Packer side
    modport slave (
        input  start, num_rows, result_in, result_valid, out_ready,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/result_packer.sv
// result_packer: saturates Q20.12 row results to Q4.12 and packs BANDWIDTH lanes per output word.
// Latency: a word shows on out_valid the cycle after the result that completes it.
// Backpressure: none on input; a word completing while the output still holds an unaccepted word is dropped (overrun).
// Optional feature macro: BIAS_ADD_EN adds a per-row Q4.12 bias table summed in before saturation.
module result_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_ROWS   = 64,
    parameter int BANDWIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    result_packer_if.slave                bus,
    output logic                          busy,
    output logic                          sat_flag,
    output logic                          overrun
`ifdef BIAS_ADD_EN
    ,
    input  logic                          bias_we,
    input  logic [$clog2(MAX_ROWS)-1:0]   bias_addr,
    input  logic signed [DATA_WIDTH-1:0]  bias_in
`endif
);
    localparam int CNT_W  = $clog2(MAX_ROWS) + 1;
    localparam int LANE_W = (BANDWIDTH > 1) ? $clog2(BANDWIDTH) : 1;
    localparam int WORD_W = DATA_WIDTH * BANDWIDTH;
`ifdef BIAS_ADD_EN
    localparam int SUM_W  = 2 * DATA_WIDTH + 1;
`else
    localparam int SUM_W  = 2 * DATA_WIDTH;
`endif
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH} state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [CNT_W-1:0]               r_rows;
    logic [CNT_W-1:0]               r_row;
    logic [LANE_W-1:0]              r_lane;
    logic [WORD_W-1:0]              r_pack;
    logic [WORD_W-1:0]              r_out_data;
    logic                           r_out_valid;
    logic                           r_out_last;
    logic                           r_sat;
    logic                           r_overrun;

    logic                           w_start_job;
    logic                           w_accept;
    logic                           w_last_row;
    logic                           w_lane_full;
    logic                           w_word_done;
    logic                           w_hs;
    logic                           w_out_free;
    logic                           w_load;
    logic signed [SUM_W-1:0]        w_sum;
    logic                           w_clamp;
    logic [DATA_WIDTH-1:0]          w_sat_val;
    logic [WORD_W-1:0]              w_pack_merged;

`ifdef BIAS_ADD_EN
    localparam int ADDR_W = $clog2(MAX_ROWS);
    logic signed [DATA_WIDTH-1:0]   r_bias [MAX_ROWS];
    logic signed [DATA_WIDTH-1:0]   w_bias;

    // Bias table write port; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (bias_we) begin
            r_bias[bias_addr] <= bias_in;
        end
    end

    assign w_bias = r_bias[r_row[ADDR_W-1:0]];
    // One extra bit so result + bias can never wrap before saturation
    assign w_sum  = {bus.result_in[2*DATA_WIDTH-1], bus.result_in}
                  + {{(DATA_WIDTH+1){w_bias[DATA_WIDTH-1]}}, w_bias};
`else
    assign w_sum  = bus.result_in;
`endif

    assign w_accept    = (r_state == S_COLLECT) && bus.result_valid;
    assign w_last_row  = (r_row == r_rows - CNT_W'(1));
    assign w_lane_full = (r_lane == LANE_W'(BANDWIDTH - 1));
    assign w_word_done = w_accept && (w_lane_full || w_last_row);
    assign w_hs        = r_out_valid && bus.out_ready;
    // The output slot can take a new word if empty or emptying this cycle
    assign w_out_free  = !r_out_valid || w_hs;
    assign w_load      = w_word_done && w_out_free;

    // Clamp to the Q4.12 range; fractional bits pass through untouched
    always_comb begin
        w_clamp   = 1'b0;
        w_sat_val = w_sum[DATA_WIDTH-1:0];
        if (w_sum > SAT_MAX) begin
            w_clamp   = 1'b1;
            w_sat_val = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_clamp   = 1'b1;
            w_sat_val = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    // Pack register with the current result dropped into its lane
    always_comb begin
        w_pack_merged = r_pack;
        w_pack_merged[r_lane*DATA_WIDTH +: DATA_WIDTH] = w_sat_val;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a zero-row job is acknowledged but never leaves IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_start_job = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_start_job = 1'b1;
                    if (bus.num_rows != '0) begin
                        w_state_nxt = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (w_accept && w_last_row) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Exits on the final handshake, or at once if the last word was dropped and the slot is empty
                if (!r_out_valid || w_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Row/lane counters, pack register and sticky per-job flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rows    <= '0;
            r_row     <= '0;
            r_lane    <= '0;
            r_pack    <= '0;
            r_sat     <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_start_job) begin
            r_rows    <= bus.num_rows;
            r_row     <= '0;
            r_lane    <= '0;
            r_pack    <= '0;
            r_sat     <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_accept) begin
            r_row <= r_row + CNT_W'(1);
            if (w_clamp) begin
                r_sat <= 1'b1;
            end
            if (w_word_done) begin
                r_lane <= '0;
                r_pack <= '0;
                if (!w_out_free) begin
                    r_overrun <= 1'b1;
                end
            end else begin
                r_lane <= r_lane + LANE_W'(1);
                r_pack <= w_pack_merged;
            end
        end
    end

    // Output word register, held until the consumer accepts it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_pack_merged;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last_row;
        end else if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign sat_flag      = r_sat;
    assign overrun       = r_overrun;
endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: table vectors, hand-written corner sequences and a randomized job run against a word-level model.
// Latency: checks sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: out_ready is driven by the bench (held, pulsed or randomized).
module tb_result_packer;
    localparam int DW = 16;
    localparam int MR = 64;
    localparam int CW = $clog2(MR) + 1;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [CW-1:0]        num_rows;
    logic signed [31:0]   result_in;
    logic                 result_valid;
    logic                 out_ready;
    logic                 busy4, sat4, ovr4;
    logic                 busy16, sat16, ovr16;
`ifdef BIAS_ADD_EN
    logic                 bias_we;
    logic [5:0]           bias_addr;
    logic signed [15:0]   bias_in;
`endif

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    result_packer_if #(.DATA_WIDTH(DW), .MAX_ROWS(MR), .BANDWIDTH(4))  bus4 ();
    result_packer_if #(.DATA_WIDTH(DW), .MAX_ROWS(MR), .BANDWIDTH(16)) bus16 ();

    assign bus4.start         = start;
    assign bus4.num_rows      = num_rows;
    assign bus4.result_in     = result_in;
    assign bus4.result_valid  = result_valid;
    assign bus4.out_ready     = out_ready;
    assign bus16.start        = start;
    assign bus16.num_rows     = num_rows;
    assign bus16.result_in    = result_in;
    assign bus16.result_valid = result_valid;
    assign bus16.out_ready    = out_ready;

    result_packer #(.DATA_WIDTH(DW), .MAX_ROWS(MR), .BANDWIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .busy(busy4), .sat_flag(sat4), .overrun(ovr4)
`ifdef BIAS_ADD_EN
        , .bias_we(bias_we), .bias_addr(bias_addr), .bias_in(bias_in)
`endif
    );

    result_packer #(.DATA_WIDTH(DW), .MAX_ROWS(MR), .BANDWIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16), .busy(busy16), .sat_flag(sat16), .overrun(ovr16)
`ifdef BIAS_ADD_EN
        , .bias_we(bias_we), .bias_addr(bias_addr), .bias_in(bias_in)
`endif
    );

    // Handshake monitors
    logic [63:0]  mon4_d[$];
    bit           mon4_l[$];
    logic [255:0] mon16_d[$];
    bit           mon16_l[$];

    always @(posedge clk) begin
        if (!rst && bus4.out_valid && bus4.out_ready) begin
            mon4_d.push_back(bus4.out_data);
            mon4_l.push_back(bus4.out_last);
        end
        if (!rst && bus16.out_valid && bus16.out_ready) begin
            mon16_d.push_back(bus16.out_data);
            mon16_l.push_back(bus16.out_last);
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int satq(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    typedef struct packed {
        int               n;
        logic [0:5][31:0] res;
        logic [63:0]      w0;
        logic [63:0]      w1;
        int               nw;
        logic             sat;
    } vec_t;

    function automatic vec_t mk(input int n, input int r0, input int r1, input int r2,
                                input int r3, input int r4, input int r5,
                                input logic [63:0] w0, input logic [63:0] w1,
                                input int nw, input logic sat);
        vec_t v;
        v.n = n;
        v.res[0] = r0; v.res[1] = r1; v.res[2] = r2;
        v.res[3] = r3; v.res[4] = r4; v.res[5] = r5;
        v.w0 = w0; v.w1 = w1; v.nw = nw; v.sat = sat;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; num_rows = '0; result_in = '0; result_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_job(input int n);
        start = 1'b1;
        num_rows = CW'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int v);
        result_in = v;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic wait_idle4(input int budget);
        int c = 0;
        while (busy4 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("idle_wait_bw4", busy4, 1'b0);
    endtask

    task automatic wait_idle16(input int budget);
        int c = 0;
        while (busy16 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("idle_wait_bw16", busy16, 1'b0);
    endtask

    // One randomized job on the 4-lane packer against a word-level model
    task automatic run_random_job(input int n);
        int          vals[$];
        logic [63:0] words[$];
        logic [63:0] w;
        logic [63:0] m_data = '0;
        int          sent = 0, wi = 0, cyc = 0, r;
        bit          m_full = 0, m_last = 0, m_ovr = 0, m_sat = 0, hs, done, rv;
        for (int k = 0; k < n; k++) begin
            r = int'($urandom_range(0, 120000)) - 60000;
            vals.push_back(r);
            if (satq(r) != r) m_sat = 1;
        end
        // Expected words: consecutive groups of four saturated results, unused lanes zero
        for (int k = 0; k < n; k += 4) begin
            w = '0;
            for (int j = 0; j < 4 && k + j < n; j++) w[j*16 +: 16] = 16'(satq(vals[k+j]));
            words.push_back(w);
        end
        start_job(n);
        while ((sent < n || m_full) && cyc < 400) begin
            chk("rnd_valid", bus4.out_valid, m_full);
            if (m_full) begin
                chk("rnd_data", bus4.out_data, m_data);
                chk("rnd_last", bus4.out_last, m_last);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rv   = (sent < n) && ($urandom_range(0, 4) != 0);
            hs   = m_full && out_ready;
            done = rv && ((sent + 1 == n) || ((sent + 1) % 4 == 0));
            if (done) begin
                if (!m_full || hs) begin
                    m_full = 1; m_data = words[wi]; m_last = (sent + 1 == n);
                end else begin
                    m_ovr = 1;
                end
                wi++;
            end else if (hs) begin
                m_full = 0;
            end
            if (rv) begin
                result_in = vals[sent];
                sent++;
            end
            result_valid = rv;
            @(negedge clk);
            cyc++;
        end
        result_valid = 1'b0;
        chk("rnd_end_busy", busy4, 1'b0);
        chk("rnd_end_valid", bus4.out_valid, 1'b0);
        chk("rnd_sat", sat4, m_sat);
        chk("rnd_overrun", ovr4, m_ovr);
    endtask

    vec_t         vecs [6];
    logic [255:0] w16_exp;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(4, 12288, 0, -4096, 8192, 0, 0, pack4(12288, 0, -4096, 8192), 64'h0, 1, 1'b0);
        vecs[1] = mk(4, 40960, 0, 40960, -40000, 0, 0, pack4(32767, 0, 32767, -32768), 64'h0, 1, 1'b1);
        vecs[2] = mk(6, 100, -200, 300, -400, 500, -600, pack4(100, -200, 300, -400), pack4(500, -600, 0, 0), 2, 1'b0);
        vecs[3] = mk(1, -32768, 0, 0, 0, 0, 0, pack4(-32768, 0, 0, 0), 64'h0, 1, 1'b0);
        vecs[4] = mk(3, 32768, -32769, 32767, 0, 0, 0, pack4(32767, -32768, 32767, 0), 64'h0, 1, 1'b1);
        vecs[5] = mk(5, 4096, 4096, 4096, 4096, 4096, 0, pack4(4096, 4096, 4096, 4096), pack4(4096, 0, 0, 0), 2, 1'b0);

`ifdef BIAS_ADD_EN
        bias_we = 1'b0; bias_addr = '0; bias_in = '0;
`endif
        do_reset();
`ifdef BIAS_ADD_EN
        for (int a = 0; a < MR; a++) begin
            bias_we = 1'b1; bias_addr = 6'(a); bias_in = '0;
            @(negedge clk);
        end
        bias_we = 1'b0;
`endif

        // Reset state
        chk("rst_out_valid", bus4.out_valid, 1'b0);
        chk("rst_out_last", bus4.out_last, 1'b0);
        chk("rst_out_data", bus4.out_data, 64'h0);
        chk("rst_busy", busy4, 1'b0);
        chk("rst_sat", sat4, 1'b0);
        chk("rst_overrun", ovr4, 1'b0);

        // Table vectors, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mon4_d.delete(); mon4_l.delete();
            start_job(vecs[i].n);
            for (int k = 0; k < vecs[i].n; k++) send(vecs[i].res[k]);
            wait_idle4(30);
            chk($sformatf("v%0d_words", i), mon4_d.size(), vecs[i].nw);
            if (mon4_d.size() > 0) begin
                chk($sformatf("v%0d_w0", i), mon4_d[0], vecs[i].w0);
                chk($sformatf("v%0d_last0", i), mon4_l[0], vecs[i].nw == 1);
            end
            if (mon4_d.size() > 1) begin
                chk($sformatf("v%0d_w1", i), mon4_d[1], vecs[i].w1);
                chk($sformatf("v%0d_last1", i), mon4_l[1], 1'b1);
            end
            chk($sformatf("v%0d_sat", i), sat4, vecs[i].sat);
            chk($sformatf("v%0d_overrun", i), ovr4, 1'b0);
        end

        // Latency, hold under backpressure and overrun
        out_ready = 1'b0;
        start_job(8);
        send(1000); send(2000); send(3000);
        chk("lat_before", bus4.out_valid, 1'b0);
        send(4000);
        chk("lat_valid", bus4.out_valid, 1'b1);
        chk("hold_data", bus4.out_data, pack4(1000, 2000, 3000, 4000));
        chk("hold_no_overrun", ovr4, 1'b0);
        send(-1000); send(-2000); send(-3000); send(-4000);
        chk("drop_data_kept", bus4.out_data, pack4(1000, 2000, 3000, 4000));
        chk("drop_valid_kept", bus4.out_valid, 1'b1);
        chk("drop_last_kept", bus4.out_last, 1'b0);
        chk("drop_overrun", ovr4, 1'b1);
        chk("drop_busy", busy4, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drop_release_busy", busy4, 1'b0);
        chk("drop_release_valid", bus4.out_valid, 1'b0);

        // Reset in the middle of a job
        out_ready = 1'b1;
        start_job(8);
        send(50000); send(1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy4, 1'b0);
        chk("midrst_valid", bus4.out_valid, 1'b0);
        chk("midrst_data", bus4.out_data, 64'h0);
        chk("midrst_sat", sat4, 1'b0);
        rst = 1'b0;
        mon4_d.delete(); mon4_l.delete();
        send(5); send(6); send(7); send(8);
        repeat (3) @(negedge clk);
        chk("midrst_no_output", mon4_d.size(), 0);

        // Zero-row job stays idle
        start_job(0);
        chk("zero_rows_busy", busy4, 1'b0);
        send(11); send(12); send(13); send(14);
        repeat (2) @(negedge clk);
        chk("zero_rows_no_output", mon4_d.size(), 0);

        // Start pulse during a job is ignored
        start_job(4);
        send(10);
        start = 1'b1; num_rows = CW'(1);
        @(negedge clk);
        start = 1'b0;
        send(20); send(30); send(40);
        wait_idle4(20);
        chk("restart_words", mon4_d.size(), 1);
        if (mon4_d.size() > 0) begin
            chk("restart_data", mon4_d[0], pack4(10, 20, 30, 40));
            chk("restart_last", mon4_l[0], 1'b1);
        end

        // Sixteen-lane packer, 32 rows
        do_reset();
        mon4_d.delete(); mon4_l.delete(); mon16_d.delete(); mon16_l.delete();
        out_ready = 1'b1;
        w16_exp = {16{16'h1000}};
        start_job(32);
        for (int k = 0; k < 32; k++) send(4096);
        wait_idle16(20);
        chk("bw16_words", mon16_d.size(), 2);
        if (mon16_d.size() == 2) begin
            chk("bw16_w0", mon16_d[0], w16_exp);
            chk("bw16_w1", mon16_d[1], w16_exp);
            chk("bw16_last0", mon16_l[0], 1'b0);
            chk("bw16_last1", mon16_l[1], 1'b1);
        end
        chk("bw16_sat", sat16, 1'b0);
        chk("bw4_same_job_words", mon4_d.size(), 8);

        // Randomized jobs with random gaps and random consumer stalls
        for (int j = 0; j < 25; j++) run_random_job(int'($urandom_range(1, 14)));

`ifdef BIAS_ADD_EN
        bias_we = 1'b1; bias_addr = 6'd0; bias_in = -16'sd4096;
        @(negedge clk);
        bias_we = 1'b0;
        mon4_d.delete(); mon4_l.delete();
        out_ready = 1'b1;
        start_job(1);
        send(8192);
        wait_idle4(20);
        chk("bias_words", mon4_d.size(), 1);
        if (mon4_d.size() > 0) chk("bias_lane0", mon4_d[0], pack4(4096, 0, 0, 0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/result_packer.md
RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning output element width (Q4.12).
REQ-002 SHALL have parameter MAX_ROWS, default 64, meaning the largest supported result vector length.
REQ-003 SHALL have parameter BANDWIDTH, default 16, meaning elements per output word.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a one-cycle pulse that begins a job.
REQ-007 SHALL have port num_rows, input, $clog2(MAX_ROWS)+1, the row count, sampled at start.
REQ-008 SHALL have port result_in, input, 2*DATA_WIDTH signed, a Q20.12 row result from the multiplier.
REQ-009 SHALL have port result_valid, input, 1, result_in qualifier; no backpressure exists on this side.
REQ-010 SHALL have port out_data, output, DATA_WIDTH*BANDWIDTH, the packed Q4.12 word.
REQ-011 SHALL have port out_valid, output, 1, out_data qualifier.
REQ-012 SHALL have port out_ready, input, 1, consumer accept.
REQ-013 SHALL have port out_last, output, 1, flags the final word of the job.
REQ-014 SHALL have port busy, output, 1, high when not IDLE.
REQ-015 SHALL have port sat_flag, output, 1, sticky per-job saturation indicator.
REQ-016 SHALL have port overrun, output, 1, sticky per-job lost-word error.

Function
REQ-017 SHALL implement states IDLE, COLLECT and FLUSH; start in IDLE latches num_rows, clears row and lane counters, sat_flag and overrun, and enters COLLECT; start outside IDLE is ignored.
REQ-018 SHALL convert each accepted result_in to DATA_WIDTH bits by saturating to [-32768, 32767] (fractional bits unchanged), setting sat_flag whenever it clamps.
REQ-019 SHALL place row r in lane r mod BANDWIDTH at bits [lane*DATA_WIDTH +: DATA_WIDTH] of a pack register; result_valid is ignored outside COLLECT.
REQ-020 SHALL complete a word when lane reaches BANDWIDTH-1 or row reaches num_rows-1, moving it to the output register so out_valid rises the cycle after the completing result (1-cycle latency); lanes never written are zero.
REQ-021 SHALL hold out_data, out_valid and out_last stable until out_valid && out_ready, clearing out_valid on that cycle unless a new word loads simultaneously.
REQ-022 SHALL, when a word completes while the output register holds an unaccepted word, keep the older word, drop the new word, and set overrun.
REQ-023 SHALL assert out_last on the word containing row num_rows-1, move to FLUSH, and return to IDLE on the handshake of that word.
REQ-024 SHALL, when num_rows is 0 at start, stay in IDLE and emit nothing.

Reset
REQ-025 SHALL on rst drive out_valid, out_last, busy, sat_flag and overrun to 0, out_data to 0, all counters to 0, state to IDLE; rst mid-job abandons it with no further output.

Configuration
REQ-026 SHALL, when BIAS_ADD_EN is defined, add ports bias_we (1), bias_addr ($clog2(MAX_ROWS)) and bias_in (DATA_WIDTH signed) writing a MAX_ROWS-entry Q4.12 bias table, and add the sign-extended bias[r] to result_in in a 2*DATA_WIDTH+1 bit sum before saturation; the bias table is not cleared by rst.
REQ-027 SHALL, when BIAS_ADD_EN is undefined, have no bias ports or storage and saturate result_in directly.

Verification
REQ-028 SHALL test BANDWIDTH=4, num_rows=4, results 12288, 0, -4096, 8192 -> one word with lanes 12288, 0, -4096, 8192, out_last=1, sat_flag=0.
REQ-029 SHALL test BANDWIDTH=4, num_rows=4, results 40960, 0, 40960, -40000 -> lanes 32767, 0, 32767, -32768, sat_flag=1.
REQ-030 SHALL test BANDWIDTH=16, num_rows=32, all results 4096, out_ready=1 -> two words of sixteen 4096, out_last only on the second, then IDLE.
REQ-031 SHALL test BANDWIDTH=4, num_rows=6 -> second word lanes 2..3 zero, out_last=1.
REQ-032 SHALL test out_ready held 0 across two completed words -> first word held intact, overrun=1; rst mid-job -> busy=0, out_valid=0 next cycle.
REQ-033 SHALL test, with BIAS_ADD_EN, bias[0]=-4096 and result 8192 -> lane 0 = 4096.
